// File: rtl/ucsbece154a_mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// State encodings follow the defines used by the multicycle datapath.
package ucsbece154a_mem_responder_pkg;

  typedef enum logic [1:0] {
    mresp_idle = 2'b00,
    mresp_wait = 2'b01,
    mresp_resp = 2'b10
  } mresp_state_t;

  localparam logic [31:0] MRESP_ERR_DATA = 32'h0000_0000;

  // Misaligned or beyond the last word of the backing store.
  function automatic logic mresp_addr_err(input logic [31:0] addr, input logic [29:0] depth);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= depth);
  endfunction

endpackage

// File: rtl/ucsbece154a_ram_sp.sv
// Single-port word RAM: byte-enabled synchronous write, registered read.
// Read data holds its value until the next read enable.
module ucsbece154a_ram_sp #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ucsbece154a_mem_responder.sv
// Memory-side responder: one request at a time, serviced from a local RAM
// after LATENCY wait cycles, answered through a valid/ready response port.
//
// state      | meaning
// mresp_idle | ready for a request; accepting latches it
// mresp_wait | counting down the inserted latency
// mresp_resp | response held until the consumer takes it
module ucsbece154a_mem_responder
  import ucsbece154a_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT   = 4'(LATENCY);
  localparam logic [29:0] DEPTH = 30'(DEPTH_WORDS);

  mresp_state_t state, state_n;
  logic [3:0]   cnt;
  logic         we_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic [3:0]   be_q;
  logic         rd_q;
  logic         err_q;

  logic         accept;
  logic         acc_now;
  logic         acc_we;
  logic [31:0]  acc_addr;
  logic [31:0]  acc_wdata;
  logic [3:0]   acc_be;
  logic         acc_err;
  logic         ram_re;
  logic [3:0]   ram_we;
  logic [31:0]  ram_rdata;

  assign accept = (state == mresp_idle) && req_valid_i;

  // With no latency the access happens on the accept edge, so it must use
  // the live request rather than the latched copy.
  always_comb begin
    acc_now   = (state == mresp_wait) && (cnt == 4'd1);
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (LAT == 4'd0) begin
      acc_now   = accept;
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end
  end

  assign acc_err = mresp_addr_err(acc_addr, DEPTH);
  assign ram_re  = acc_now && !acc_we && !acc_err;
  assign ram_we  = (acc_now && acc_we && !acc_err) ? acc_be : 4'b0000;

  ucsbece154a_ram_sp #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= mresp_idle;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      mresp_idle: if (req_valid_i) state_n = (LAT == 4'd0) ? mresp_resp : mresp_wait;
      mresp_wait: if (cnt == 4'd1) state_n = mresp_resp;
      mresp_resp: if (resp_ready_i) state_n = mresp_idle;
      default:    state_n = mresp_idle;
    endcase
  end

  always_comb begin
    req_ready_o  = (state == mresp_idle);
    resp_valid_o = (state == mresp_resp);
    resp_err_o   = (state == mresp_resp) && err_q;
    resp_rdata_o = MRESP_ERR_DATA;
    if ((state == mresp_resp) && rd_q) resp_rdata_o = ram_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= LAT;
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end else if (state == mresp_wait) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_now) begin
        rd_q  <= !acc_we && !acc_err;
        err_q <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154a_mem_responder.sv
// Bench for the memory responder: a LATENCY=2 and a LATENCY=0 instance,
// each checked against an array model of the backing store.
module tb_ucsbece154a_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;

  logic        rdy_a, rvalid_a, err_a, rdy_b, rvalid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rdy, rvalid, rerr;
  logic [31:0] rdata;

  assign rdy    = sel ? rdy_b    : rdy_a;
  assign rvalid = sel ? rvalid_b : rvalid_a;
  assign rerr   = sel ? err_b    : err_a;
  assign rdata  = sel ? rdata_b  : rdata_a;

  ucsbece154a_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid && !sel), .req_ready_o(rdy_a),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(rvalid_a), .resp_ready_i(resp_ready && !sel),
    .resp_rdata_o(rdata_a), .resp_err_o(err_a)
  );

  ucsbece154a_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid && sel), .req_ready_o(rdy_b),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .resp_valid_o(rvalid_b), .resp_ready_i(resp_ready && sel),
    .resp_rdata_o(rdata_b), .resp_err_o(err_b)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [2][64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural store: word array, byte-granular writes, errors leave it alone.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] exp_rdata,
                              output logic exp_err);
    exp_err   = (addr % 4 != 0) || (addr / 4 >= 64);
    exp_rdata = 32'h0;
    if (!exp_err) begin
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[sel][addr / 4][8*k +: 8] = wdata[8*k +: 8];
      end else begin
        exp_rdata = ref_mem[sel][addr / 4];
      end
    end
  endtask

  task automatic wait_accept();
    logic ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy) begin
        @(posedge clk);
        #1 req_valid = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      check_eq("ready_valid_excl", 32'(rdy && rvalid), 32'd0);
      if (rvalid) break;
      check_eq("busy_not_ready", 32'(rdy), 32'd0);
    end
    if (!rvalid) check_eq("resp_timeout", 32'(rvalid), 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input string tag);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n;
    model_access(we, addr, wdata, be, exp_rdata, exp_err);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1; resp_ready = 1'b1;
    wait_accept();
    wait_resp(n);
    check_eq({tag, "_lat"}, 32'(n), sel ? 32'd1 : 32'd3);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_err"}, 32'(rerr), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return {24'h0, 3'($urandom_range(0, 7)), 5'h0} | 32'({$urandom_range(0, 7), 2'b00});
    if (r == 7) return 32'({$urandom_range(0, 63), 2'b00}) | 32'($urandom_range(1, 3));
    return ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
  endfunction

  initial begin
    int n, acc_cnt, val_cnt;
    logic [31:0] held;

    #23 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_a", 32'(rdy_a), 32'd1);
    check_eq("rst_valid_a", 32'(rvalid_a), 32'd0);
    check_eq("rst_rdata_a", rdata_a, 32'd0);
    check_eq("rst_err_a", 32'(err_a), 32'd0);
    check_eq("rst_ready_b", 32'(rdy_b), 32'd1);
    check_eq("rst_valid_b", 32'(rvalid_b), 32'd0);
    @(posedge clk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, "preload");
    end
    sel = 1'b0;

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    do_req(1'b0, 32'h10, 32'h0, 4'h0, "rd10");
    check_eq("rd10_value", ref_mem[0][4], 32'hDEADBEEF);

    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, "wr20");
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "wr20_be");
    do_req(1'b0, 32'h20, 32'h0, 4'hF, "rd20");
    check_eq("be_merge_model", ref_mem[0][8], 32'h11BB33DD);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, "wr20_be0");
    do_req(1'b0, 32'h20, 32'h0, 4'h0, "rd20_after_be0");

    do_req(1'b0, 32'h22, 32'h0, 4'hF, "rd_misaligned");
    do_req(1'b1, 32'h400, 32'h55555555, 4'hF, "wr_oor");
    do_req(1'b1, 32'h2, 32'h66666666, 4'hF, "wr_misaligned");
    do_req(1'b0, 32'h0, 32'h0, 4'hF, "rd0_unchanged");

    // Backpressure: response held five cycles while another request waits.
    req_we = 1'b0; req_addr = 32'h20; req_be = 4'hF;
    req_valid = 1'b1; resp_ready = 1'b0;
    wait_accept();
    wait_resp(n);
    check_eq("bp_lat", 32'(n), 32'd3);
    held = rdata;
    check_eq("bp_rdata", held, 32'h11BB33DD);
    req_addr = 32'h10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid_held", 32'(rvalid), 32'd1);
      check_eq("bp_rdata_held", rdata, held);
      check_eq("bp_not_ready", 32'(rdy), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_after_hs_ready", 32'(rdy), 32'd1);
    check_eq("bp_after_hs_valid", 32'(rvalid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(n);
    check_eq("bp_next_lat", 32'(n), 32'd3);
    check_eq("bp_next_rdata", rdata, ref_mem[0][4]);
    @(posedge clk); #1;

    // Reset in WAIT during a write: the write must not land.
    do_req(1'b1, 32'h30, 32'h12345678, 4'hF, "wr30");
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    req_valid = 1'b1;
    wait_accept();
    #2 reset = 1'b0;
    #1 check_eq("rst_wait_valid", 32'(rvalid_a), 32'd0);
    check_eq("rst_wait_rdata", rdata_a, 32'd0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_wait_ready_after", 32'(rdy_a), 32'd1);
    @(posedge clk); #1;
    do_req(1'b0, 32'h30, 32'h0, 4'hF, "rd30_after_rst");

    // Reset in RESP: a held response must vanish before the next edge.
    req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    wait_accept();
    wait_resp(n);
    check_eq("rst_resp_pre_valid", 32'(rvalid_a), 32'd1);
    #2 reset = 1'b0;
    #1 check_eq("rst_resp_valid", 32'(rvalid_a), 32'd0);
    check_eq("rst_resp_rdata", rdata_a, 32'd0);
    check_eq("rst_resp_err", 32'(err_a), 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 30; i++)
        do_req(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    // LATENCY=0: continuous reads sustain one request per two cycles.
    sel = 1'b1;
    req_we = 1'b0; req_addr = 32'h8; req_be = 4'hF;
    req_valid = 1'b1; resp_ready = 1'b1;
    acc_cnt = 0; val_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("l0_excl", 32'(rdy_b && rvalid_b), 32'd0);
      if (rdy_b) acc_cnt++;
      if (rvalid_b) begin
        val_cnt++;
        check_eq("l0_rdata", rdata_b, ref_mem[1][2]);
      end
    end
    req_valid = 1'b0;
    check_eq("l0_accepts", 32'(acc_cnt), 32'd10);
    check_eq("l0_responses", 32'(val_cnt), 32'd10);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
